tt3_sweep_driver: RTL and testbench

//   Upstream stimulus stage for 3-input combinational gates such as truth-table module 0x8A.
//   On start, drives all 8 input vectors {in1,in2,in3} = 000..111 in turn.
//   For each vector it waits a settle window, then samples the gate's output.
//   It assembles the measured 8-bit truth-table word in the codebase's hex naming order and compares it to an expected word.

---
 rtl/tt3_sweep_driver.sv | 137 +++++++++++++
 tb/tb_tt3_sweep_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt3_sweep_driver.sv
// Sweeps {in1,in2,in3} through 000..111 and samples the gate output after a settle window.
// Assembles the measured truth-table word (row 000 -> bit 7) and compares it to a latched reference.
module tt3_sweep_driver #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_word,
  output logic       match
);

  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 3 to cover the 2-flop synchroniser");
  end
  if ((2 ** CNT_W) <= SETTLE_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for SETTLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic [2:0]       r_vec;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_tt;
  logic [7:0]       r_exp;
  logic             r_match;
  logic [7:0]       w_tt_smp;
  logic             w_accept;

  assign w_accept = start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SETTLE;
      SETTLE: begin
        if (abort)                 w_state_nxt = IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)              w_state_nxt = IDLE;
        else if (r_vec == 3'd7) w_state_nxt = DONE;
        else                    w_state_nxt = SETTLE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word including the bit being sampled now, so match can be registered on DONE entry.
  always_comb begin
    w_tt_smp = r_tt;
    w_tt_smp[3'd7 - r_vec] = r_sync2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_tt    <= '0;
      r_exp   <= '0;
      r_match <= 1'b0;
    end else begin
      r_sync1 <= dut_out;
      r_sync2 <= r_sync1;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_vec   <= '0;
            r_cnt   <= '0;
            r_tt    <= '0;
            r_match <= 1'b0;
            r_exp   <= expected;
          end
        end
        SETTLE: begin
          if (abort) begin
            r_vec   <= '0;
            r_match <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            r_vec   <= '0;
            r_match <= 1'b0;
          end else begin
            r_tt <= w_tt_smp;
            if (r_vec == 3'd7) begin
              r_vec   <= '0;
              r_match <= (w_tt_smp == r_exp);
            end else begin
              r_vec <= r_vec + 3'd1;
              r_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign {in1, in2, in3} = r_vec;
  assign busy            = (r_state == SETTLE) || (r_state == SAMPLE);
  assign done            = (r_state == DONE);
  assign tt_word         = r_tt;
  assign match           = r_match;

endmodule

// File: tb/tb_tt3_sweep_driver.sv
// Bench for tt3_sweep_driver: a SETTLE=4 instance with an ideal gate and a SETTLE=3 instance
// whose gate output lags by just under two clocks. Directed table, reset/corner sequences, random sweeps.
module tb_tt3_sweep_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic [7:0] gate_tt = 8'h00;

  logic       in1, in2, in3, busy, done, match, dut_out;
  logic [7:0] tt_word;
  logic       in1_3, in2_3, in3_3, busy_3, done_3, match_3, dut_out_3;
  logic [7:0] tt_word_3;
  logic [2:0] w_v4, w_v3;
  logic       g3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign w_v4 = {in1, in2, in3};
  assign w_v3 = {in1_3, in2_3, in3_3};
  assign dut_out = gate_tt[3'd7 - w_v4];
  assign g3 = gate_tt[3'd7 - w_v3];
  assign #18 dut_out_3 = g3;

  tt3_sweep_driver u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .dut_out(dut_out), .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
    .tt_word(tt_word), .match(match)
  );

  tt3_sweep_driver #(.SETTLE_CYCLES(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .dut_out(dut_out_3), .in1(in1_3), .in2(in2_3), .in3(in3_3), .busy(busy_3), .done(done_3),
    .tt_word(tt_word_3), .match(match_3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Cycle c is the interval after start-edge + (c-1) further edges; abort a is seen at edge a.
  function automatic void model_cycle(input int s, input int c, input int a,
                                      output logic mb, output logic [2:0] mv, output logic md);
    int e, len;
    bit ab;
    e   = c - 1;
    len = 8 * (s + 1);
    ab  = (a > 0) && (a <= len) && (e >= a);
    mb  = !ab && (e < len);
    mv  = mb ? 3'(e / (s + 1)) : 3'd0;
    md  = !ab && (e == len);
  endfunction

  function automatic logic [7:0] model_tt(input logic [7:0] g, input int s, input int a);
    logic [7:0] t;
    t = 8'h00;
    for (int v = 0; v < 8; v++)
      if (a == 0 || a > 8 * (s + 1) || (s + 1) * (v + 1) < a) t[7 - v] = g[7 - v];
    return t;
  endfunction

  function automatic int model_done(input int s, input int a);
    return (a == 0 || a > 8 * (s + 1)) ? 8 * (s + 1) + 1 : 0;
  endfunction

  task automatic run_sweep(input string nm, input logic [7:0] g, input logic [7:0] e,
                           input int ab, input int rs,
                           input logic [7:0] x_tt, input logic x_m, input int x_done,
                           input logic [7:0] x_tt3, input int x_done3);
    int d4, d3;
    logic mb, md;
    logic [2:0] mv;
    logic x_m3;
    d4 = 0;
    d3 = 0;
    x_m3 = (x_done3 != 0) && (x_tt3 == e);
    gate_tt = g;
    @(negedge clk);
    start = 1'b1;
    expected = e;
    @(posedge clk);
    #1;
    start = 1'b0;
    expected = ~e;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      model_cycle(4, c, ab, mb, mv, md);
      check($sformatf("%s busy c%0d", nm, c), 32'(busy), 32'(mb));
      check($sformatf("%s vec c%0d", nm, c), 32'(w_v4), 32'(mv));
      check($sformatf("%s done c%0d", nm, c), 32'(done), 32'(md));
      if (done) begin
        if (d4 == 0) d4 = c;
        check($sformatf("%s match@done", nm), 32'(match), 32'(x_m));
      end
      model_cycle(3, c, ab, mb, mv, md);
      check($sformatf("%s busy3 c%0d", nm, c), 32'(busy_3), 32'(mb));
      check($sformatf("%s vec3 c%0d", nm, c), 32'(w_v3), 32'(mv));
      check($sformatf("%s done3 c%0d", nm, c), 32'(done_3), 32'(md));
      if (done_3 && d3 == 0) d3 = c;
      abort = (c == ab);
      start = (c == rs);
    end
    abort = 1'b0;
    start = 1'b0;
    check({nm, " tt_word"}, 32'(tt_word), 32'(x_tt));
    check({nm, " match"}, 32'(match), 32'(x_m));
    check({nm, " done cycle"}, 32'(d4), 32'(x_done));
    check({nm, " tt_word3"}, 32'(tt_word_3), 32'(x_tt3));
    check({nm, " match3"}, 32'(match_3), 32'(x_m3));
    check({nm, " done cycle3"}, 32'(d3), 32'(x_done3));
  endtask

  typedef struct {
    string      nm;
    logic [7:0] g;
    logic [7:0] e;
    int         ab;
    int         rs;
    logic [7:0] x_tt;
    logic       x_m;
    int         x_done;
    logic [7:0] x_tt3;
    int         x_done3;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"gate8A",       8'h8A, 8'h8A, 0,  0,  8'h8A, 1'b1, 41, 8'h8A, 33};
    tbl[1] = '{"tied0",        8'h00, 8'h8A, 0,  0,  8'h00, 1'b0, 41, 8'h00, 33};
    tbl[2] = '{"abort_v3",     8'h8A, 8'h8A, 17, 0,  8'h80, 1'b0, 0,  8'h80, 0};
    tbl[3] = '{"restart_c10",  8'h8A, 8'h8A, 0,  10, 8'h8A, 1'b1, 41, 8'h8A, 33};
    tbl[4] = '{"gate96",       8'h96, 8'h8A, 0,  0,  8'h96, 1'b0, 41, 8'h96, 33};
    tbl[5] = '{"abort_row7",   8'hFF, 8'hFF, 40, 0,  8'hFE, 1'b0, 0,  8'hFF, 33};
    tbl[6] = '{"abort_indone", 8'h8A, 8'h8A, 41, 0,  8'h8A, 1'b1, 41, 8'h8A, 33};

    #2;
    check("reset outputs", 32'({in1, in2, in3, busy, done, tt_word, match}), 32'h0);
    check("reset outputs3", 32'({in1_3, in2_3, in3_3, busy_3, done_3, tt_word_3, match_3}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_sweep(tbl[i].nm, tbl[i].g, tbl[i].e, tbl[i].ab, tbl[i].rs,
                tbl[i].x_tt, tbl[i].x_m, tbl[i].x_done, tbl[i].x_tt3, tbl[i].x_done3);

    // Reset asserted mid-sweep, between clock edges.
    gate_tt = 8'h8A;
    @(negedge clk);
    start = 1'b1;
    expected = 8'h8A;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset outputs", 32'({in1, in2, in3, busy, done, tt_word, match}), 32'h0);
    check("midreset outputs3", 32'({in1_3, in2_3, in3_3, busy_3, done_3, tt_word_3, match_3}), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midreset held", 32'({busy, done, busy_3, done_3}), 32'h0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("post-reset idle", 32'({busy, done, busy_3, done_3}), 32'h0);
    end
    run_sweep("after_reset", 8'h8A, 8'h8A, 0, 0, 8'h8A, 1'b1, 41, 8'h8A, 33);

    // start and abort together in IDLE: start dropped, results untouched.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start+abort busy", 32'({busy, busy_3}), 32'h0);
    repeat (2) @(negedge clk);
    check("start+abort held", 32'({busy, done, tt_word, match}), 32'({2'b00, 8'h8A, 1'b1}));
    // abort alone in IDLE.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("idle abort", 32'({busy, done, tt_word, match, tt_word_3, match_3}),
          32'({2'b00, 8'h8A, 1'b1, 8'h8A, 1'b1}));

    for (int i = 0; i < 12; i++) begin
      logic [7:0] g, e;
      int ab, rs;
      g  = 8'($urandom);
      e  = ($urandom_range(0, 1) == 1) ? g : 8'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 44)) : 0;
      rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0;
      if (ab != 0 && rs >= ab) rs = 0;
      run_sweep($sformatf("rand%0d", i), g, e, ab, rs,
                model_tt(g, 4, ab), (model_done(4, ab) != 0) && (g == e), model_done(4, ab),
                model_tt(g, 3, ab), model_done(3, ab));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
